wb_arbiter: RTL and testbench

- Writeback arbiter directly upstream of the integer register file.
- Collects results from three execution sources (MEM, MUL, ALU) over valid/ready handshakes and grants one per cycle to the register file's single write port (wr_rd/wr_data).
- Registers the winning result; the same registered value is exported as a forwarding bus for decode/execute bypass.
- Fixed priority with anti-starvation promotion.

---
 rtl/wb_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of MEM/MUL/ALU per cycle for the single
// register-file write port, with wait counters that promote a source that
// has been passed over too long. The registered winner doubles as the
// forwarding bus.

package PARAMS_pkg;
    parameter int WD_SIZE        = 32;
    parameter int INSTR_REG_BITS = 5;
endpackage

module wb_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int CNT_BITS       = 3,
    parameter int WD_SIZE        = PARAMS_pkg::WD_SIZE,
    parameter int INSTR_REG_BITS = PARAMS_pkg::INSTR_REG_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic [INSTR_REG_BITS-1:0] mem_rd,
    input  logic [WD_SIZE-1:0]        mem_data,
    output logic                      mem_ready,
    input  logic                      mul_valid,
    input  logic [INSTR_REG_BITS-1:0] mul_rd,
    input  logic [WD_SIZE-1:0]        mul_data,
    output logic                      mul_ready,
    input  logic                      alu_valid,
    input  logic [INSTR_REG_BITS-1:0] alu_rd,
    input  logic [WD_SIZE-1:0]        alu_data,
    output logic                      alu_ready,
    output logic [INSTR_REG_BITS-1:0] wr_rd,
    output logic [WD_SIZE-1:0]        wr_data,
    output logic                      fwd_valid,
    output logic [INSTR_REG_BITS-1:0] fwd_rd,
    output logic [WD_SIZE-1:0]        fwd_data
);

    // Counters must be able to hold the promotion threshold.
    if ((1 << CNT_BITS) <= STARVE_LIMIT) begin : g_bad_cnt_bits
        $error("CNT_BITS too small for STARVE_LIMIT");
    end

    localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(STARVE_LIMIT);

    // Index 0 = MEM, 1 = MUL, 2 = ALU; index order is also base priority.
    logic [2:0]                          valid;
    logic [2:0][INSTR_REG_BITS-1:0]      rd;
    logic [2:0][WD_SIZE-1:0]             data;
    logic [2:0]                          rd_zero;
    logic [2:0]                          cand;
    logic [2:0]                          starved;
    logic [2:0]                          grant;
    logic                                block;
    logic [CNT_BITS-1:0]                 cnt [3];
    logic [INSTR_REG_BITS-1:0]           sel_rd;
    logic [WD_SIZE-1:0]                  sel_data;

    assign valid = {alu_valid, mul_valid, mem_valid};
    assign rd    = {alu_rd, mul_rd, mem_rd};
    assign data  = {alu_data, mul_data, mem_data};
    assign block = reset | flush;

    // Classify each source: rd==0 bypass, write candidate, starved candidate.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_zero[i] = (rd[i] == '0);
            cand[i]    = valid[i] & ~rd_zero[i];
            starved[i] = cand[i] & (cnt[i] == LIMIT);
        end
    end

    // Starved candidates outrank everything; within a class, MEM > MUL > ALU.
    always_comb begin
        grant = 3'b000;
        if (!block) begin
            if (|starved) begin
                if (starved[0])      grant = 3'b001;
                else if (starved[1]) grant = 3'b010;
                else                 grant = 3'b100;
            end else begin
                if (cand[0])         grant = 3'b001;
                else if (cand[1])    grant = 3'b010;
                else if (cand[2])    grant = 3'b100;
            end
        end
    end

    // rd==0 results are simply drained; real writes need the grant.
    assign mem_ready = ~block & valid[0] & (rd_zero[0] | grant[0]);
    assign mul_ready = ~block & valid[1] & (rd_zero[1] | grant[1]);
    assign alu_ready = ~block & valid[2] & (rd_zero[2] | grant[2]);

    // Mux the granted result; zeros when nobody wins so the slot reads as idle.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_rd   = rd[i];
                sel_data = data[i];
            end
        end
    end

    // Per-source wait counters, saturating at the promotion threshold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (block || grant[i] || !cand[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] != LIMIT) begin
                cnt[i] <= cnt[i] + CNT_BITS'(1);
            end
        end
    end

    // Output register feeding both the register file and the bypass network.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_rd     <= '0;
            wr_data   <= '0;
            fwd_valid <= 1'b0;
        end else begin
            wr_rd     <= sel_rd;
            wr_data   <= sel_data;
            fwd_valid <= |grant;
        end
    end

    assign fwd_rd   = wr_rd;
    assign fwd_data = wr_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized stream, all checked every cycle against a behavioural model.

module tb_wb_arbiter;

    localparam int RB  = 5;
    localparam int WD  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [2:0]    v;
    logic [RB-1:0] rd  [3];
    logic [WD-1:0] dat [3];

    logic          mem_ready, mul_ready, alu_ready;
    logic [RB-1:0] wr_rd, fwd_rd;
    logic [WD-1:0] wr_data, fwd_data;
    logic          fwd_valid;

    always #5 clk = ~clk;

    wb_arbiter #(
        .STARVE_LIMIT(LIM), .CNT_BITS(3), .WD_SIZE(WD), .INSTR_REG_BITS(RB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .mem_valid(v[0]), .mem_rd(rd[0]), .mem_data(dat[0]), .mem_ready(mem_ready),
        .mul_valid(v[1]), .mul_rd(rd[1]), .mul_data(dat[1]), .mul_ready(mul_ready),
        .alu_valid(v[2]), .alu_rd(rd[2]), .alu_data(dat[2]), .alu_ready(alu_ready),
        .wr_rd(wr_rd), .wr_data(wr_data), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: how long each source has waited, and the write due next cycle.
    int            mcnt [3];
    logic [RB-1:0] exp_rd;
    logic [WD-1:0] exp_data;

    // Values sampled in the most recent cycle, for directed checks.
    logic          s_rdy [3];
    logic [RB-1:0] s_wr_rd;
    logic [WD-1:0] s_wr_data;
    logic          s_fwd_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance it.
    task automatic cycle();
        int   g;
        logic er [3];
        @(negedge clk);
        g = -1;
        for (int i = 0; i < 3; i++) er[i] = 1'b0;
        if (!reset && !flush) begin
            for (int i = 0; i < 3; i++)
                if (g < 0 && v[i] && rd[i] != 0 && mcnt[i] == LIM) g = i;
            for (int i = 0; i < 3; i++)
                if (g < 0 && v[i] && rd[i] != 0) g = i;
            for (int i = 0; i < 3; i++)
                er[i] = v[i] && (rd[i] == 0 || g == i);
        end
        s_rdy[0]    = mem_ready;
        s_rdy[1]    = mul_ready;
        s_rdy[2]    = alu_ready;
        s_wr_rd     = wr_rd;
        s_wr_data   = wr_data;
        s_fwd_valid = fwd_valid;
        chk("mem_ready", 64'(mem_ready), 64'(er[0]));
        chk("mul_ready", 64'(mul_ready), 64'(er[1]));
        chk("alu_ready", 64'(alu_ready), 64'(er[2]));
        chk("wr_rd", 64'(wr_rd), 64'(exp_rd));
        chk("wr_data", 64'(wr_data), 64'(exp_data));
        chk("fwd_rd", 64'(fwd_rd), 64'(exp_rd));
        chk("fwd_data", 64'(fwd_data), 64'(exp_data));
        chk("fwd_valid", 64'(fwd_valid), 64'(exp_rd != 0));
        @(posedge clk);
        if (reset) begin
            exp_rd   = '0;
            exp_data = '0;
        end else if (g >= 0) begin
            exp_rd   = rd[g];
            exp_data = dat[g];
        end else begin
            exp_rd   = '0;
            exp_data = '0;
        end
        for (int i = 0; i < 3; i++) begin
            if (reset || flush || g == i || !v[i] || rd[i] == 0) mcnt[i] = 0;
            else if (mcnt[i] < LIM) mcnt[i] = mcnt[i] + 1;
        end
        #1;
    endtask

    // A cycle in which every source whose result was taken drops valid.
    task automatic step();
        cycle();
        for (int i = 0; i < 3; i++) if (s_rdy[i]) v[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        v     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rd[i] = '0; dat[i] = '0; mcnt[i] = 0;
        end
        exp_rd   = '0;
        exp_data = '0;
        @(posedge clk);
        #1;

        // Reset held with every source requesting.
        v = 3'b111;
        rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
        dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33;
        repeat (2) begin
            step();
            chk("rst_ready", 64'({s_rdy[0], s_rdy[1], s_rdy[2]}), 64'd0);
            chk("rst_wr_rd", 64'(s_wr_rd), 64'd0);
            chk("rst_fwd_valid", 64'(s_fwd_valid), 64'd0);
        end
        reset = 1'b0;
        step();
        chk("first_mem_ready", 64'(s_rdy[0]), 64'd1);
        chk("first_mul_ready", 64'(s_rdy[1]), 64'd0);
        repeat (4) step();

        // Three simultaneous results drain in base-priority order.
        v = 3'b111;
        rd[0] = 5'd5; rd[1] = 5'd6; rd[2] = 5'd7;
        dat[0] = 32'hA; dat[1] = 32'hB; dat[2] = 32'hC;
        step();
        chk("sim_c0_mem", 64'(s_rdy[0]), 64'd1);
        chk("sim_c0_mul", 64'(s_rdy[1]), 64'd0);
        step();
        chk("sim_c1_mul", 64'(s_rdy[1]), 64'd1);
        chk("sim_c1_wr_rd", 64'(s_wr_rd), 64'd5);
        chk("sim_c1_wr_data", 64'(s_wr_data), 64'hA);
        step();
        chk("sim_c2_alu", 64'(s_rdy[2]), 64'd1);
        chk("sim_c2_wr_rd", 64'(s_wr_rd), 64'd6);
        chk("sim_c2_wr_data", 64'(s_wr_data), 64'hB);
        step();
        chk("sim_c3_wr_rd", 64'(s_wr_rd), 64'd7);
        chk("sim_c3_wr_data", 64'(s_wr_data), 64'hC);
        step();

        // Starvation: MEM streams new results, ALU rd=3 waits and gets promoted.
        v = 3'b101;
        rd[0] = 5'd10; dat[0] = 32'h100;
        rd[2] = 5'd3;  dat[2] = 32'h33;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k < 4) begin
                chk("starve_mem_ready", 64'(s_rdy[0]), 64'd1);
                chk("starve_alu_wait", 64'(s_rdy[2]), 64'd0);
            end else if (k == 4) begin
                chk("starve_alu_ready", 64'(s_rdy[2]), 64'd1);
                chk("starve_mem_held", 64'(s_rdy[0]), 64'd0);
                chk("starve_wr_rd_mem", 64'(s_wr_rd), 64'd13);
            end else begin
                chk("starve_wr_rd_alu", 64'(s_wr_rd), 64'd3);
                chk("starve_mem_resume", 64'(s_rdy[0]), 64'd1);
            end
            if (s_rdy[0]) begin
                rd[0]  = rd[0] + 5'd1;
                dat[0] = dat[0] + 32'd1;
            end
            if (s_rdy[2]) v[2] = 1'b0;
        end
        v = 3'b000;
        repeat (2) step();

        // rd==0 result drains alongside a real write.
        v = 3'b101;
        rd[0] = 5'd9; dat[0] = 32'h99;
        rd[2] = 5'd0; dat[2] = 32'hFF;
        step();
        chk("rd0_mem_ready", 64'(s_rdy[0]), 64'd1);
        chk("rd0_alu_ready", 64'(s_rdy[2]), 64'd1);
        step();
        chk("rd0_wr_rd", 64'(s_wr_rd), 64'd9);
        chk("rd0_wr_data", 64'(s_wr_data), 64'h99);
        step();
        chk("rd0_no_write", 64'(s_wr_rd), 64'd0);

        // Flush: the already-registered write survives, new requests wait.
        v = 3'b010;
        rd[1] = 5'd4; dat[1] = 32'h44;
        step();
        chk("flush_mul_acc", 64'(s_rdy[1]), 64'd1);
        v[0] = 1'b1; rd[0] = 5'd8; dat[0] = 32'h88;
        flush = 1'b1;
        step();
        chk("flush_wr_rd", 64'(s_wr_rd), 64'd4);
        chk("flush_mem_ready", 64'(s_rdy[0]), 64'd0);
        flush = 1'b0;
        step();
        chk("flush_after_wr_rd", 64'(s_wr_rd), 64'd0);
        chk("flush_after_mem", 64'(s_rdy[0]), 64'd1);
        step();
        chk("flush_mem_wr_rd", 64'(s_wr_rd), 64'd8);
        chk("flush_mem_wr_data", 64'(s_wr_data), 64'h88);

        // Reset while a write is registered discards it the following cycle.
        v = 3'b001;
        rd[0] = 5'd12; dat[0] = 32'hC0;
        step();
        reset = 1'b1;
        step();
        chk("midrst_wr_rd", 64'(s_wr_rd), 64'd12);
        reset = 1'b0;
        step();
        chk("midrst_cleared", 64'(s_wr_rd), 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 1000; n++) begin
            flush = ($urandom % 32) == 0;
            reset = ($urandom % 200) == 0;
            for (int i = 0; i < 3; i++) begin
                if (!v[i]) begin
                    v[i]   = ($urandom % 4) != 0;
                    rd[i]  = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    dat[i] = $urandom;
                end
            end
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        v     = 3'b000;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
